// File: rtl/multi_ch_clkdiv_if.sv
// multi_ch_clkdiv_if: control and status bundle for the multi-channel clock divider
interface multi_ch_clkdiv_if #(parameter int NUM_CH = 4, parameter int WIDTH = 8);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*WIDTH-1:0] div_in;
    logic [NUM_CH*WIDTH-1:0] high_in;
    logic [NUM_CH-1:0]       load;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;
    modport master (output en, div_in, high_in, load, sync, input clk_out, tick, pending);
    modport slave  (input en, div_in, high_in, load, sync, output clk_out, tick, pending);
endinterface

// File: rtl/multi_ch_clkdiv.sv
// multi_ch_clkdiv: NUM_CH glitch-free programmable dividers; settings are shadowed and
// only take effect at a period boundary, and a common sync forces a boundary on all channels.
module multi_ch_clkdiv #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) (
    input logic clk,
    input logic reset,
    multi_ch_clkdiv_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] r_div_a, r_high_a, r_div_s, r_high_s, r_cnt;
        logic             r_clk, r_tick, r_pend;
        logic [WIDTH-1:0] w_cnt_next, w_cnt_n, w_div_n, w_high_n, w_h_eff;
        logic             w_stop, w_bnd, w_take;
        always_comb begin
            w_stop     = r_div_a == '0;
            w_cnt_next = (r_cnt == r_div_a - ONE) ? '0 : r_cnt + ONE;
            w_bnd      = bus.sync | (w_cnt_next == '0);
            w_take     = bus.en[g] & r_pend & (w_stop | w_bnd);
            w_div_n    = w_take ? r_div_s : r_div_a;
            w_high_n   = w_take ? r_high_s : r_high_a;
            w_h_eff    = (w_high_n < w_div_n) ? w_high_n : w_div_n;
            w_cnt_n    = w_bnd ? '0 : w_cnt_next;
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                r_div_a  <= WIDTH'(2);
                r_high_a <= ONE;
                r_div_s  <= WIDTH'(2);
                r_high_s <= ONE;
                r_cnt    <= '0;
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
                r_pend   <= 1'b0;
            end else begin
                if (bus.load[g]) begin
                    r_div_s  <= bus.div_in[g*WIDTH +: WIDTH];
                    r_high_s <= bus.high_in[g*WIDTH +: WIDTH];
                end
                r_pend <= bus.load[g] | (r_pend & ~w_take);
                if (w_take) begin
                    r_div_a  <= r_div_s;
                    r_high_a <= r_high_s;
                end
                // parking cnt at N-1 makes the first enabled edge a boundary
                if (!bus.en[g]) begin
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    r_cnt  <= w_stop ? '0 : r_div_a - ONE;
                end else if (w_stop) begin
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    r_cnt  <= (w_take && r_div_s != '0) ? r_div_s - ONE : '0;
                end else begin
                    r_cnt  <= w_cnt_n;
                    r_tick <= w_bnd;
                    r_clk  <= w_cnt_n < w_h_eff;
                end
            end
        end
        assign bus.clk_out[g] = r_clk;
        assign bus.tick[g]    = r_tick;
        assign bus.pending[g] = r_pend;
    end
endmodule

// File: tb/tb_multi_ch_clkdiv.sv
// tb_multi_ch_clkdiv: scoreboard bench; a period-position reference model predicts every cycle's outputs
module tb_multi_ch_clkdiv;
    localparam int NC = 4;
    localparam int W  = 8;
    logic clk = 1'b0;
    logic reset;
    multi_ch_clkdiv_if #(.NUM_CH(NC), .WIDTH(W)) bus ();
    multi_ch_clkdiv #(.NUM_CH(NC), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [3*NC-1:0] q[$];
    int m_n[NC], m_h[NC], m_sn[NC], m_sh[NC], m_pos[NC];
    bit m_pend[NC], m_fresh[NC];

    // position-in-period model: pos counts cycles since the last period start
    task automatic model_step();
        logic [NC-1:0] c, t, p;
        for (int i = 0; i < NC; i++) begin
            bit applied = 0;
            bit bnd;
            c[i] = 0;
            t[i] = 0;
            if (reset) begin
                m_n[i] = 2; m_h[i] = 1; m_sn[i] = 2; m_sh[i] = 1;
                m_pos[i] = 0; m_fresh[i] = 0; m_pend[i] = 0;
            end else begin
                if (!bus.en[i]) m_fresh[i] = 1;
                else if (m_n[i] == 0) begin
                    if (m_pend[i]) begin m_n[i] = m_sn[i]; m_h[i] = m_sh[i]; applied = 1; end
                    m_fresh[i] = 1;
                end else begin
                    bnd = bus.sync || m_fresh[i] || (m_pos[i] + 1 == m_n[i]);
                    m_fresh[i] = 0;
                    if (bnd) begin
                        if (m_pend[i]) begin m_n[i] = m_sn[i]; m_h[i] = m_sh[i]; applied = 1; end
                        m_pos[i] = 0;
                    end else m_pos[i]++;
                    t[i] = bnd;
                    c[i] = m_pos[i] < ((m_h[i] < m_n[i]) ? m_h[i] : m_n[i]);
                end
                m_pend[i] = bus.load[i] || (m_pend[i] && !applied);
                if (bus.load[i]) begin
                    m_sn[i] = int'(bus.div_in[i*W +: W]);
                    m_sh[i] = int'(bus.high_in[i*W +: W]);
                end
            end
            p[i] = m_pend[i];
        end
        q.push_back({c, t, p});
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            bus.load = '0;
            bus.sync = 1'b0;
        end
    endtask

    task automatic ld(int ch, int n, int h);
        bus.load[ch] = 1'b1;
        bus.div_in[ch*W +: W] = W'(n);
        bus.high_in[ch*W +: W] = W'(h);
    endtask

    task automatic chk(string name, logic [NC-1:0] got, logic [NC-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cyc, got, exp);
        end
    endtask

    initial begin
        logic [3*NC-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("clk_out", bus.clk_out, e[3*NC-1:2*NC]);
                chk("tick", bus.tick, e[2*NC-1:NC]);
                chk("pending", bus.pending, e[NC-1:0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.en = '0; bus.div_in = '0; bus.high_in = '0; bus.load = '0; bus.sync = 1'b0;
        @(negedge clk);
        step(3);
        reset = 1'b0;
        bus.en = '1;
        step(8);
        ld(0, 5, 2); step(1); step(20);
        ld(1, 4, 2); step(1); step(6);
        ld(1, 6, 3); step(1); ld(1, 3, 1); step(12);
        ld(1, 4, 2); step(2); ld(1, 5, 1); step(10);
        ld(0, 3, 1); ld(1, 7, 3); ld(2, 10, 5); bus.en[3] = 1'b0; step(1); step(25);
        bus.sync = 1'b1; step(1); step(6);
        bus.en = '1;
        ld(0, 4, 0); ld(1, 5, 8); ld(2, 1, 1); ld(3, 0, 0); step(1); step(12);
        ld(3, 4, 2); step(1); step(10);
        step(2); bus.en[0] = 1'b0; step(3); bus.en[0] = 1'b1; step(6);
        ld(2, 6, 3); step(2); reset = 1'b1; step(1); reset = 1'b0; step(8);
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < NC; i++) begin
                bus.en[i] = ($urandom_range(0, 19) != 0);
                if ($urandom_range(0, 9) == 0) ld(i, $urandom_range(0, 9), $urandom_range(0, 11));
            end
            bus.sync = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset = 1'b0;
        step(3);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain cycle=%0d got=%0d expected=0", cyc, q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
